// File: rtl/servant_irq_pkg.sv
// Shared definitions for the servant external-interrupt generator: register map,
// FSM state encoding, CTRL/STATUS bit positions and a saturating increment helper.
package servant_irq_pkg;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_PERIOD  = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_LATENCY = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_ASSERT  = 2'd2,
        ST_SERVICE = 2'd3
    } irq_state_e;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_RELOAD_BIT = 1;
    localparam int STATUS_CLR_BIT  = 0;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/servant_irq_latency_ctr.sv
// 16-bit saturating start/stop counter used to measure interrupt acceptance latency.
module servant_irq_latency_ctr
    import servant_irq_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        inc_i,
    output logic [15:0] count_o
);

    logic [15:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (start_i) begin
            count_q <= '0;
        end else if (inc_i) begin
            count_q <= sat_inc16(count_q);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/servant_ext_irq_gen.sv
// Programmable external-interrupt source with a Wishbone control slave.
// Optional latency measurement enabled by defining SERVANT_EXT_IRQ_GEN_LATENCY_EN.
module servant_ext_irq_gen
    import servant_irq_pkg::*;
#(
    parameter logic [31:0] default_period = 32'd3000,
    parameter bit          auto_start     = 1'b0,
    parameter bit          auto_reload    = 1'b1
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic [3:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    input  logic        i_new_irq,
    input  logic        i_mret,
    output logic        o_ext_irq
);

    irq_state_e  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] period_q, period_d;
    logic        en_q, en_d;
    logic        reload_q, reload_d;
    logic        irq_q, irq_d;
    logic [15:0] svc_q, svc_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] rd_data;
    logic [15:0] lat_cnt;
    logic        wr_ack, ctrl_wr, period_wr, status_clr;
    logic        unused_adr;

    assign unused_adr = ^i_wb_adr[1:0];

    // Writes commit on the acknowledge cycle.
    assign wr_ack     = ack_q & i_wb_cyc & i_wb_we;
    assign ctrl_wr    = wr_ack & (i_wb_adr[3:2] == REG_CTRL);
    assign period_wr  = wr_ack & (i_wb_adr[3:2] == REG_PERIOD);
    assign status_clr = wr_ack & (i_wb_adr[3:2] == REG_STATUS) & i_wb_dat[STATUS_CLR_BIT];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        en_d     = en_q;
        reload_d = reload_q;
        irq_d    = irq_q;
        svc_d    = svc_q;
        if (period_wr) begin
            period_d = i_wb_dat;
        end
        if (ctrl_wr) begin
            en_d     = i_wb_dat[CTRL_EN_BIT];
            reload_d = i_wb_dat[CTRL_RELOAD_BIT];
        end
        if (ctrl_wr && !i_wb_dat[CTRL_EN_BIT]) begin
            state_d = ST_IDLE;
            irq_d   = 1'b0;
        end else if (status_clr && (state_q == ST_ASSERT || state_q == ST_SERVICE)) begin
            // Force clear completes the service exactly like an mret would.
            irq_d = 1'b0;
            if (reload_q) begin
                state_d = ST_COUNT;
                cnt_d   = period_q;
            end else begin
                state_d = ST_IDLE;
                en_d    = 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ctrl_wr) begin
                        state_d = ST_COUNT;
                        cnt_d   = period_q;
                    end
                end
                ST_COUNT: begin
                    // Stopping at 1 makes PERIOD=0 behave as PERIOD=1.
                    if (cnt_q <= 32'd1) begin
                        state_d = ST_ASSERT;
                        irq_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                ST_ASSERT: begin
                    if (i_new_irq) begin
                        state_d = ST_SERVICE;
                        irq_d   = 1'b0;
                        svc_d   = sat_inc16(svc_q);
                    end
                end
                ST_SERVICE: begin
                    if (i_mret) begin
                        if (reload_q) begin
                            state_d = ST_COUNT;
                            cnt_d   = period_q;
                        end else begin
                            state_d = ST_IDLE;
                            en_d    = 1'b0;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        case (i_wb_adr[3:2])
            REG_CTRL:    rd_data = {30'd0, reload_q, en_q};
            REG_PERIOD:  rd_data = period_q;
            REG_STATUS:  rd_data = {svc_q, 13'd0, irq_q, state_q};
            REG_LATENCY: rd_data = {16'd0, lat_cnt};
            default:     rd_data = '0;
        endcase
    end

    assign ack_d = i_wb_cyc & ~ack_q;
    assign dat_d = ack_d ? rd_data : 32'd0;

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q  <= auto_start ? ST_COUNT : ST_IDLE;
            cnt_q    <= auto_start ? default_period : 32'd0;
            period_q <= default_period;
            en_q     <= auto_start;
            reload_q <= auto_reload;
            irq_q    <= 1'b0;
            svc_q    <= '0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            en_q     <= en_d;
            reload_q <= reload_d;
            irq_q    <= irq_d;
            svc_q    <= svc_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
        end
    end

`ifdef SERVANT_EXT_IRQ_GEN_LATENCY_EN
    logic lat_start, lat_inc;

    // Counts only while ASSERT persists, so any exit (accept or forced) freezes it.
    assign lat_start = (state_q != ST_ASSERT) && (state_d == ST_ASSERT);
    assign lat_inc   = (state_q == ST_ASSERT) && (state_d == ST_ASSERT);

    servant_irq_latency_ctr u_latency_ctr (
        .clk_i   (wb_clk),
        .rst_i   (wb_rst),
        .start_i (lat_start),
        .inc_i   (lat_inc),
        .count_o (lat_cnt)
    );
`else
    assign lat_cnt = 16'd0;
`endif

    assign o_wb_ack  = ack_q;
    assign o_wb_dat  = dat_q;
    assign o_ext_irq = irq_q;

endmodule

// File: tb/tb_servant_ext_irq_gen.sv
// Directed bench for servant_ext_irq_gen: timing of arm-to-irq, service handshake,
// register priorities, asynchronous reset and the optional latency readout.
module tb_servant_ext_irq_gen;

    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b1;
    logic [3:0]  i_wb_adr = '0;
    logic [31:0] i_wb_dat = '0;
    logic        i_wb_we = 1'b0;
    logic        i_wb_cyc = 1'b0;
    logic [31:0] o_wb_dat;
    logic        o_wb_ack;
    logic        i_new_irq = 1'b0;
    logic        i_mret = 1'b0;
    logic        o_ext_irq;

    int n_checks = 0;
    int n_errors = 0;

    servant_ext_irq_gen #(
        .default_period (32'd3000),
        .auto_start     (1'b1),
        .auto_reload    (1'b1)
    ) dut (
        .wb_clk    (wb_clk),
        .wb_rst    (wb_rst),
        .i_wb_adr  (i_wb_adr),
        .i_wb_dat  (i_wb_dat),
        .i_wb_we   (i_wb_we),
        .i_wb_cyc  (i_wb_cyc),
        .o_wb_dat  (o_wb_dat),
        .o_wb_ack  (o_wb_ack),
        .i_new_irq (i_new_irq),
        .i_mret    (i_mret),
        .o_ext_irq (o_ext_irq)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
        i_wb_adr = a;
        i_wb_dat = d;
        i_wb_we  = 1'b1;
        i_wb_cyc = 1'b1;
        @(posedge wb_clk);
        #1;
        check_eq("wr_ack", 32'(o_wb_ack), 32'd1);
        @(posedge wb_clk);
        #1;
        i_wb_cyc = 1'b0;
        i_wb_we  = 1'b0;
    endtask

    task automatic wb_read(input logic [3:0] a, output logic [31:0] d);
        i_wb_adr = a;
        i_wb_we  = 1'b0;
        i_wb_cyc = 1'b1;
        @(posedge wb_clk);
        #1;
        check_eq("rd_ack", 32'(o_wb_ack), 32'd1);
        d = o_wb_dat;
        @(posedge wb_clk);
        #1;
        i_wb_cyc = 1'b0;
    endtask

    task automatic pulse_new_irq();
        i_new_irq = 1'b1;
        @(posedge wb_clk);
        #1;
        i_new_irq = 1'b0;
    endtask

    task automatic pulse_mret();
        i_mret = 1'b1;
        @(posedge wb_clk);
        #1;
        i_mret = 1'b0;
    endtask

    // Counts clock edges until o_ext_irq is seen high, bounded.
    task automatic wait_irq(input int start, output int n);
        n = start;
        while (!o_ext_irq && n < 5000) begin
            @(posedge wb_clk);
            n++;
            #1;
        end
    endtask

    logic [31:0] rd;
    int          n;
    logic [31:0] exp_lat;

    initial begin
`ifdef SERVANT_EXT_IRQ_GEN_LATENCY_EN
        exp_lat = 32'd7;
`else
        exp_lat = 32'd0;
`endif
        repeat (3) @(posedge wb_clk);
        #1;
        check_eq("rst_irq", 32'(o_ext_irq), 32'd0);
        check_eq("rst_ack", 32'(o_wb_ack), 32'd0);
        check_eq("rst_dat", o_wb_dat, 32'd0);

        // auto_start: irq 3000 cycles after reset release
        @(negedge wb_clk);
        wb_rst = 1'b0;
        wait_irq(0, n);
        check_eq("autostart_period", 32'(n), 32'd3000);

        wb_read(4'h8, rd);
        check_eq("status_assert", rd, 32'h0000_0006);
        wb_write(4'h4, 32'd20);
        pulse_new_irq();
        check_eq("irq_drop", 32'(o_ext_irq), 32'd0);
        wb_read(4'h8, rd);
        check_eq("status_service", rd, 32'h0001_0003);
        pulse_mret();
        wait_irq(0, n);
        check_eq("reload_period", 32'(n), 32'd20);

        // reload=0: completion returns to IDLE and clears en
        wb_write(4'h0, 32'h1);
        pulse_new_irq();
        wb_read(4'h8, rd);
        check_eq("status_service2", rd, 32'h0002_0003);
        pulse_mret();
        wb_read(4'h0, rd);
        check_eq("ctrl_after_noreload", rd, 32'h0);
        wb_read(4'h8, rd);
        check_eq("status_idle", rd, 32'h0002_0000);

        // PERIOD=0 behaves as 1
        wb_write(4'h4, 32'd0);
        wb_write(4'h0, 32'h3);
        check_eq("p0_not_yet", 32'(o_ext_irq), 32'd0);
        @(posedge wb_clk);
        #1;
        check_eq("p0_rise", 32'(o_ext_irq), 32'd1);
        wb_write(4'h0, 32'h2);
        check_eq("ctrl_off_irq", 32'(o_ext_irq), 32'd0);
        wb_read(4'h8, rd);
        check_eq("status_off", rd, 32'h0002_0000);

        // PERIOD written mid-count applies only at the next reload
        wb_write(4'h4, 32'd30);
        wb_write(4'h0, 32'h3);
        wb_write(4'h4, 32'd10);
        wait_irq(2, n);
        check_eq("cur_period", 32'(n), 32'd30);
        pulse_new_irq();
        pulse_mret();
        wait_irq(0, n);
        check_eq("next_period", 32'(n), 32'd10);

        // CTRL en=0 wins over a simultaneous new_irq
        i_wb_adr = 4'h0;
        i_wb_dat = 32'h2;
        i_wb_we  = 1'b1;
        i_wb_cyc = 1'b1;
        @(posedge wb_clk);
        #1;
        i_new_irq = 1'b1;
        @(posedge wb_clk);
        #1;
        i_new_irq = 1'b0;
        i_wb_cyc  = 1'b0;
        i_wb_we   = 1'b0;
        check_eq("prio_irq", 32'(o_ext_irq), 32'd0);
        wb_read(4'h8, rd);
        check_eq("prio_status", rd, 32'h0003_0000);

        // STATUS force clear in SERVICE reloads like mret
        wb_write(4'h0, 32'h3);
        wait_irq(0, n);
        check_eq("arm_period", 32'(n), 32'd10);
        pulse_new_irq();
        wb_write(4'h8, 32'h1);
        wait_irq(0, n);
        check_eq("force_clr_reload", 32'(n), 32'd10);
        wb_read(4'h8, rd);
        check_eq("status_after_clr", rd, 32'h0004_0006);

        // acceptance 7 cycles after irq rises
        pulse_new_irq();
        pulse_mret();
        wait_irq(0, n);
        check_eq("lat_arm", 32'(n), 32'd10);
        repeat (7) @(posedge wb_clk);
        #1;
        i_new_irq = 1'b1;
        @(posedge wb_clk);
        #1;
        i_new_irq = 1'b0;
        wb_read(4'hC, rd);
        check_eq("latency", rd, exp_lat);

        // asynchronous reset during COUNT while a read is being acknowledged
        pulse_mret();
        i_wb_adr = 4'h4;
        i_wb_we  = 1'b0;
        i_wb_cyc = 1'b1;
        @(posedge wb_clk);
        #1;
        check_eq("pre_rst_ack", 32'(o_wb_ack), 32'd1);
        check_eq("pre_rst_dat", o_wb_dat, 32'd10);
        #2;
        wb_rst = 1'b1;
        #1;
        check_eq("async_ack", 32'(o_wb_ack), 32'd0);
        check_eq("async_dat", o_wb_dat, 32'd0);
        check_eq("async_irq", 32'(o_ext_irq), 32'd0);
        i_wb_cyc = 1'b0;
        repeat (2) @(posedge wb_clk);
        @(negedge wb_clk);
        wb_rst = 1'b0;
        wb_read(4'h4, rd);
        check_eq("rst_period", rd, 32'd3000);
        wb_read(4'h0, rd);
        check_eq("rst_ctrl", rd, 32'h3);
        wb_read(4'h8, rd);
        check_eq("rst_status", rd, 32'h0000_0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
